// File: rtl/align_shift_if.sv
// Handshake and operand/result bundle between the exponent-difference unit,
// the alignment stage and the mantissa add/sub stage.
interface align_shift_if #(
    parameter int EXP_MAX_W = 16,
    parameter int MAN_W     = 24
);
    logic                 start;
    logic [EXP_MAX_W:0]   diff;
    logic                 swap;
    logic [MAN_W-1:0]     m_a;
    logic [MAN_W-1:0]     m_b;
    logic                 busy;
    logic                 done;
    logic [MAN_W-1:0]     m_large;
    logic [MAN_W+1:0]     m_aligned;
    logic                 sticky;

    modport master (
        output start, diff, swap, m_a, m_b,
        input  busy, done, m_large, m_aligned, sticky
    );

    modport slave (
        input  start, diff, swap, m_a, m_b,
        output busy, done, m_large, m_aligned, sticky
    );
endinterface

// File: rtl/align_shift.sv
// FP adder mantissa alignment: iterative right shift of the smaller mantissa
// with guard/round/sticky. Optional macro ALIGN_STICKY_EN keeps the sticky logic.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | shifting up to SHIFT_STEP bits per cycle, busy=1
// DONE  | done pulse for one cycle, then back to IDLE
module align_shift #(
    parameter int EXP_MAX_W  = 16,
    parameter int MAN_W      = 24,
    parameter int SHIFT_STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    align_shift_if.slave    bus
);
    localparam int WW = MAN_W + 2;
    localparam int DW = EXP_MAX_W + 1;
    localparam int RW = $clog2(MAN_W + 3);
    localparam logic [RW-1:0] W_FULL = RW'(MAN_W + 2);
    localparam logic [RW-1:0] STEP   = RW'(SHIFT_STEP);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic             busy_r;
    logic             done_r;
    logic [MAN_W-1:0] large_r;
    logic [WW-1:0]    w;
    logic [RW-1:0]    rem;
    logic [RW-1:0]    dsat;
    logic [RW-1:0]    step;
    logic [WW-1:0]    w_next;

    // A set MSB means a negative difference; treat it as a full shift-out.
    always_comb begin
        dsat = bus.diff[RW-1:0];
        if (bus.diff[EXP_MAX_W] || (bus.diff > DW'(MAN_W + 2)))
            dsat = W_FULL;
    end

    always_comb begin
        step   = (rem < STEP) ? rem : STEP;
        w_next = w >> step;
    end

`ifdef ALIGN_STICKY_EN
    logic          sticky_r;
    logic [WW-1:0] mask;
    logic          lost;

    always_comb begin
        mask = ~({WW{1'b1}} << step);
        lost = |(w & mask);
    end

    always_ff @(posedge clk) begin
        if (rst)
            sticky_r <= 1'b0;
        else if (state == IDLE && bus.start)
            sticky_r <= 1'b0;
        else if (state == SHIFT)
            sticky_r <= sticky_r | lost;
    end

    assign bus.sticky = sticky_r;
`else
    assign bus.sticky = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            large_r <= '0;
            w       <= '0;
            rem     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        large_r <= bus.swap ? bus.m_b : bus.m_a;
                        w       <= {(bus.swap ? bus.m_a : bus.m_b), 2'b00};
                        rem     <= dsat;
                        if (dsat != '0) begin
                            state  <= SHIFT;
                            busy_r <= 1'b1;
                        end else begin
                            state  <= DONE;
                            done_r <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    w   <= w_next;
                    rem <= rem - step;
                    if (rem == step) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.m_large   = large_r;
    assign bus.m_aligned = w;
endmodule

// File: doc/align_shift.md
Name: align_shift

Overview:
- Mantissa alignment stage of the FP adder. Sits directly downstream of the exponent-difference unit and consumes its non-negative exponent difference.
- Right-shifts the mantissa with the smaller exponent by that difference, iteratively, up to SHIFT_STEP bits per cycle.
- Appends guard/round bits and accumulates a sticky bit.
- Hands the aligned pair to the mantissa add/sub stage with a start/done handshake.

Parameters:
- EXP_MAX_W, 16, exponent width; the diff input is EXP_MAX_W+1 bits.
- MAN_W, 24, mantissa width including hidden bit.
- SHIFT_STEP, 4, maximum right-shift per cycle (1..MAN_W+2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request. Sampled only in IDLE.
- diff  in  EXP_MAX_W+1  exponent difference, non-negative.
- swap  in  1  0: m_b is shifted and m_a is larger. 1: m_a is shifted and m_b is larger.
- m_a  in  MAN_W  mantissa A.
- m_b  in  MAN_W  mantissa B.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; results valid.
- m_large  out  MAN_W  unshifted mantissa.
- m_aligned  out  MAN_W+2  shifted mantissa: {mantissa, guard, round}.
- sticky  out  1  OR of all bits shifted out past round.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - busy, done and sticky are 0; m_large and m_aligned are 0.
  - Applies mid-operation: the in-flight operation is abandoned and no done is issued.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 loads m_large = swap ? m_b : m_a.
  - Working reg w = {swap ? m_a : m_b, 2'b00}. sticky_r=0.
  - rem = dsat = min(diff, MAN_W+2). If diff MSB is 1 (illegal negative), dsat = MAN_W+2.
  - Next state is SHIFT if dsat>0, else DONE. busy=1 from the next cycle.
- SHIFT, each cycle:
  - s = min(rem, SHIFT_STEP).
  - w <= w >> s. sticky_r |= OR of the s bits shifted out. rem <= rem - s.
  - Go to DONE when rem - s == 0.
- DONE:
  - done=1 for exactly one cycle, busy=0, then IDLE.
  - m_large, m_aligned and sticky hold until the next accepted start or reset.
- Latency: done asserted N+1 cycles after the start edge, with N = ceil(dsat/SHIFT_STEP). For dsat=0, done follows one cycle after start.
- start while busy or in DONE: ignored; inputs are not re-sampled.
- start in the same cycle done is high: ignored. A new start is accepted from the following IDLE cycle.
- Inputs need only be stable in the start cycle; they are captured.
- dsat=MAN_W+2: m_aligned=0; sticky = OR of the shifted mantissa.

Optional Feature:
- Macro ALIGN_STICKY_EN.
- Defined: sticky accumulates shifted-out bits as above.
- Undefined: the sticky register and OR logic are removed, sticky is tied to 0, and shifted-out bits are discarded. Latency is unchanged.

Test Plan:
(MAN_W=24, SHIFT_STEP=4, ALIGN_STICKY_EN defined unless noted)
- diff=0, swap=0, m_a=0xA00000, m_b=0x800000 -> done at start+1; m_large=0xA00000, m_aligned=0x2000000, sticky=0.
- diff=5, swap=0, m_b=0xC00001 -> busy for 2 SHIFT cycles, done at start+3; m_aligned=0x180000, sticky=1. Without ALIGN_STICKY_EN: same m_aligned and timing, sticky=0.
- diff=40, swap=0, m_b=0x000001 -> dsat=26, done at start+8; m_aligned=0, sticky=1. Repeat with diff MSB set: identical result.
- diff=2, swap=1, m_a=0x800000, m_b=0xFFFFFF -> done at start+2; m_large=0xFFFFFF, m_aligned=0x800000, sticky=0.
- Pulse start again while busy with different operands -> ignored; outputs match the first operation. start asserted on the done cycle -> ignored; accepted the next cycle.
- rst=1 during SHIFT of a diff=20 operation -> next cycle busy=0, done never pulses, all outputs 0; a subsequent start then completes normally.
